apb_prci_initiator: RTL and testbench
=====================================

Name: apb_prci_initiator

Overview:
- APB initiator that turns a simple valid/ready request/response interface into single APB3/APB4 transfers.
- Used by the debug/bring-up path to drive the PRCI register block and other APB responders in the clock/reset domain.
- One transfer is outstanding at a time. Read data and error status are returned on a registered response channel.

Parameters:
- abits, 32: address width driven on paddr.
- TIMEOUT_CYCLES, 255: access-phase cycle limit, used only when the optional feature is compiled in.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted this cycle.
- i_req_addr  in  abits  byte address.
- i_req_write  in  1  1 = write, 0 = read.
- i_req_wdata  in  32  write data.
- i_req_wstrb  in  4  byte strobes.
- o_resp_valid  out  1  response valid.
- o_resp_rdata  out  32  read data; 0 for writes.
- o_resp_err  out  1  pslverr or timeout.
- i_resp_ready  in  1  response consumed.
- o_psel  out  1  APB select.
- o_penable  out  1  APB enable.
- o_paddr  out  abits  APB address.
- o_pwrite  out  1  APB direction.
- o_pwdata  out  32  APB write data.
- o_pstrb  out  4  APB strobes; forced to 0 on reads.
- o_pprot  out  3  fixed 3'b000.
- i_pready  in  1  responder ready.
- i_prdata  in  32  responder read data.
- i_pslverr  in  1  responder error.

Behaviour:
- Reset value of every output is 0. State resets to IDLE.
- Reset asserted mid-transfer aborts immediately: psel/penable drop asynchronously and no response is issued.
- States are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_req_ready = 1 combinationally while in IDLE.
  - On i_req_valid, latch addr/write/wdata/wstrb into registers and go to SETUP.
  - Earliest acceptance is the cycle after reset release.
- SETUP:
  - o_psel = 1, o_penable = 0; paddr/pwrite/pwdata/pstrb come from the latched registers.
  - Always lasts exactly one cycle, then ACCESS.
- ACCESS:
  - o_psel = 1, o_penable = 1.
  - When i_pready = 1: capture i_prdata (reads only; writes capture 0) and i_pslverr, then go to RESP.
  - i_pslverr and i_prdata are ignored while i_pready = 0.
- RESP:
  - o_resp_valid = 1 with registered rdata/err; psel/penable = 0.
  - On i_resp_ready, go to IDLE.
  - o_resp_valid, o_resp_rdata and o_resp_err are held stable while i_resp_ready = 0.
- Timing:
  - Minimum request-accept to o_resp_valid latency is 3 cycles (SETUP, ACCESS with pready = 1, then RESP).
  - No back-to-back transfers: at least one IDLE cycle separates consecutive SETUP phases.
- APB outputs are registered: paddr/pwrite/pwdata/pstrb stay stable from SETUP through the last ACCESS cycle.
- i_req_* changes outside the IDLE acceptance cycle are ignored.
- Address bits [1:0] are passed unchanged. Alignment is not checked.
- A simultaneous i_req_valid in RESP is not accepted; o_req_ready = 0 there.

Optional Feature:
- Macro: APB_PRCI_INITIATOR_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with i_pready = 0.
  - When the count reaches TIMEOUT_CYCLES with i_pready still 0: go to RESP with o_resp_err = 1 and o_resp_rdata = 0, and drop psel/penable.
  - If i_pready = 1 in the same cycle the limit is reached, the real response wins.
- Not defined:
  - No counter is implemented; ACCESS waits on i_pready indefinitely.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Write: req addr 0x0000_0004, wdata 0xA5A5_0001, wstrb 0xF, pready tied 1 -> psel high for 2 cycles, penable high in the 2nd cycle only, pstrb 0xF; o_resp_valid 3 cycles after accept with err 0 and rdata 0.
- Read with wait states: req read 0x8, responder holds pready 0 for 4 ACCESS cycles then returns 0x1234_5678 -> rdata 0x1234_5678, err 0; paddr stable for all 5 ACCESS cycles; pstrb 0.
- Slave error: read with pslverr 1 and pready 1 -> o_resp_err 1; the next request is accepted after i_resp_ready and the following transfer returns err 0.
- Response backpressure: i_resp_ready held 0 for 10 cycles -> resp fields stable, o_req_ready 0, psel 0 throughout; the next request is accepted one cycle after the handshake.
- Reset mid-ACCESS: i_nrst pulsed low during ACCESS -> psel, penable and o_resp_valid go to 0 asynchronously; after release, a new read completes normally.
- Timeout (macro on, TIMEOUT_CYCLES = 8), pready stuck 0 -> o_resp_err 1 and rdata 0 after 8 ACCESS cycles. Same case with the macro off -> no response after 1000 cycles.

Source files
------------

// File: rtl/apb_prci_initiator.sv
// Single-outstanding APB3/APB4 initiator bridging a valid/ready request/response pair onto APB.
// Optional access-phase timeout is compiled in with APB_PRCI_INITIATOR_TIMEOUT_EN.
module apb_prci_initiator #(
  parameter int abits          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [abits-1:0] i_req_addr,
  input  logic             i_req_write,
  input  logic [31:0]      i_req_wdata,
  input  logic [3:0]       i_req_wstrb,
  output logic             o_resp_valid,
  output logic [31:0]      o_resp_rdata,
  output logic             o_resp_err,
  input  logic             i_resp_ready,
  output logic             o_psel,
  output logic             o_penable,
  output logic [abits-1:0] o_paddr,
  output logic             o_pwrite,
  output logic [31:0]      o_pwdata,
  output logic [3:0]       o_pstrb,
  output logic [2:0]       o_pprot,
  input  logic             i_pready,
  input  logic [31:0]      i_prdata,
  input  logic             i_pslverr
);

  // Handshakes: a request transfers on a rising edge where i_req_valid && o_req_ready;
  // a response transfers on a rising edge where o_resp_valid && i_resp_ready.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  logic   alive;  // holds o_req_ready low while reset is asserted

  assign o_req_ready = alive && (state == IDLE);
  assign o_pprot     = 3'b000;

`ifdef APB_PRCI_INITIATOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  // Fires on the wait cycle whose increment would bring the count to the limit.
  assign timeout_hit = (cnt == LIMIT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= IDLE;
      alive        <= 1'b0;
      o_psel       <= 1'b0;
      o_penable    <= 1'b0;
      o_paddr      <= '0;
      o_pwrite     <= 1'b0;
      o_pwdata     <= '0;
      o_pstrb      <= '0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
`ifdef APB_PRCI_INITIATOR_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: begin
          if (i_req_valid && alive) begin
            o_paddr  <= i_req_addr;
            o_pwrite <= i_req_write;
            o_pwdata <= i_req_wdata;
            o_pstrb  <= i_req_write ? i_req_wstrb : 4'h0;
            o_psel   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          state     <= ACCESS;
`ifdef APB_PRCI_INITIATOR_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        ACCESS: begin
          if (i_pready) begin
            o_resp_rdata <= o_pwrite ? 32'h0 : i_prdata;
            o_resp_err   <= i_pslverr;
            o_resp_valid <= 1'b1;
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            state        <= RESP;
          end else begin
`ifdef APB_PRCI_INITIATOR_TIMEOUT_EN
            if (timeout_hit) begin
              o_resp_rdata <= 32'h0;
              o_resp_err   <= 1'b1;
              o_resp_valid <= 1'b1;
              o_psel       <= 1'b0;
              o_penable    <= 1'b0;
              state        <= RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_prci_initiator.sv
// Scoreboard bench for apb_prci_initiator: random transfers, a behavioural APB responder,
// and directed backpressure, reset-abort and stuck-responder cases.
module tb_apb_prci_initiator;
  localparam int AB = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AB-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          resp_valid, resp_err, resp_ready;
  logic [31:0]   resp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AB-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;

  apb_prci_initiator #(.abits(AB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_nrst(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_write(req_write), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .i_resp_ready(resp_ready),
    .o_psel(psel), .o_penable(penable), .o_paddr(paddr), .o_pwrite(pwrite),
    .o_pwdata(pwdata), .o_pstrb(pstrb), .o_pprot(pprot),
    .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int waits; logic [31:0] rdata; logic err; } plan_t;
  typedef struct { logic [AB-1:0] addr; logic write; logic [31:0] wdata; logic [3:0] strb; } apb_t;

  plan_t       plan_q[$];
  apb_t        apb_q[$];
  logic [32:0] exp_q[$];   // {err, rdata}
  int          lat_q[$];   // cycle count at which the response first appears

  bit stuck    = 1'b0;
  int rr_block = 0;

  // Driver: queues the model's expectations, then presents the request until accepted.
  task automatic issue(input logic [AB-1:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] ws, input int waits, input logic [31:0] rd,
                       input logic er, input bit expect_resp);
    plan_t p;
    apb_t  x;
    int    n;
    int    acc;
    p.waits = waits; p.rdata = rd; p.err = er;
    x.addr = a; x.write = w; x.wdata = wd; x.strb = w ? ws : 4'h0;
    plan_q.push_back(p);
    apb_q.push_back(x);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd; req_wstrb = ws;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("accept_timeout", req_ready, 1);
    acc = cyc + 1;
    if (expect_resp) begin
      exp_q.push_back({er, (w ? 32'h0 : rd)});
      lat_q.push_back(acc + 2 + waits);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom; req_write = 1'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
  endtask

  // Responder: checks the setup phase against the model and answers after the planned waits.
  initial begin
    plan_t p;
    apb_t  x;
    int    wcnt;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pready = 1'b0;
      end else if (psel && !penable) begin
        if (plan_q.size() == 0 || apb_q.size() == 0) begin
          check("unplanned_setup", psel, 0);
        end else begin
          p = plan_q.pop_front();
          x = apb_q.pop_front();
          check("paddr", paddr, x.addr);
          check("pwrite", pwrite, x.write);
          check("pwdata", pwdata, x.wdata);
          check("pstrb", pstrb, x.strb);
          check("pprot", pprot, 0);
          wcnt = p.waits;
        end
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end else if (psel && penable) begin
        check("paddr_stable", {paddr, pstrb}, {x.addr, x.strb});
        if (stuck || wcnt > 0) begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
          if (wcnt > 0) wcnt--;
        end else begin
          pready = 1'b1; prdata = p.rdata; pslverr = p.err;
        end
      end else begin
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard when a response appears and checks it stays put until taken.
  initial begin
    logic [32:0] cur;
    bit have;
    bit hs;
    int l;
    have = 0; hs = 0; resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 0; hs = 0;
      end else begin
        if (hs) begin
          check("resp_drop", resp_valid, 0);
          have = 0; hs = 0;
        end
        if (resp_valid) begin
          if (!have) begin
            if (exp_q.size() == 0) begin
              check("unexpected_resp", resp_valid, 0);
            end else begin
              cur = exp_q.pop_front();
              l = lat_q.pop_front();
              check("resp_rdata", resp_rdata, cur[31:0]);
              check("resp_err", resp_err, cur[32]);
              check("resp_latency", cyc, l);
              have = 1;
            end
          end else begin
            check("resp_hold", {resp_err, resp_rdata}, cur);
          end
          check("resp_req_ready", req_ready, 0);
          check("resp_psel", {psel, penable}, 0);
          if (rr_block > 0) begin
            resp_ready = 1'b0;
            rr_block--;
          end else begin
            resp_ready = 1'($urandom_range(0, 1));
          end
          hs = resp_ready && have;
        end else begin
          resp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic flush_model();
    exp_q.delete(); lat_q.delete(); plan_q.delete(); apb_q.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_outputs", {paddr, pwdata, pstrb, pwrite, resp_rdata, resp_err}, 0);
    #2 rst_n = 1'b1;

    issue(32'h0000_0004, 1'b1, 32'hA5A5_0001, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 1);
    drain();
    issue(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4, 32'h1234_5678, 1'b0, 1);
    drain();
    issue(32'h0000_000C, 1'b0, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b1, 1);
    issue(32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0, 1);
    drain();
    rr_block = 10;
    issue(32'h0000_0023, 1'b0, 32'h0, 4'h3, 1, 32'hCAFE_0123, 1'b0, 1);
    drain();

    for (int i = 0; i < 60; i++) begin
      issue($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5),
            $urandom, 1'($urandom_range(0, 3) == 0), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Abort a transfer mid-access with reset; nothing must come back from it.
    stuck = 1'b1;
    issue(32'h0000_0040, 1'b0, 32'h0, 4'h0, 0, 32'h1111_2222, 1'b0, 0);
    n = 0;
    while (!penable && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_access", penable, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_psel", psel, 0);
    check("abort_penable", penable, 0);
    check("abort_resp_valid", resp_valid, 0);
    flush_model();
    @(negedge clk);
    #2 rst_n = 1'b1;
    stuck = 1'b0;
    issue(32'h0000_0044, 1'b0, 32'h0, 4'h0, 2, 32'h7777_8888, 1'b0, 1);
    drain();

    // Responder that never becomes ready.
    stuck = 1'b1;
`ifdef APB_PRCI_INITIATOR_TIMEOUT_EN
    issue(32'h0000_0048, 1'b0, 32'h0, 4'h0, TO - 1, 32'h0, 1'b1, 1);
    drain();
    stuck = 1'b0;
`else
    issue(32'h0000_0048, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
    repeat (1000) @(negedge clk);
    check("stuck_no_resp", resp_valid, 0);
    check("stuck_still_access", {psel, penable}, 2'b11);
    @(negedge clk);
    #2 rst_n = 1'b0;
    flush_model();
    @(negedge clk);
    #2 rst_n = 1'b1;
    stuck = 1'b0;
`endif
    issue(32'h0000_004C, 1'b1, 32'h600D_0001, 4'h5, 0, 32'h0, 1'b0, 1);
    drain();
    check("final_queue", exp_q.size() + plan_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
